// File: rtl/match_pkg.sv
// Shared widths and FSM state encoding for the match_select search block.
package match_pkg;

    localparam int RESULT_W = 18;
    localparam int PLACE_W  = 8;
    localparam int CNT_W    = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

endpackage

// File: rtl/match_select_if.sv
// Sample stream in, best/second-best search result out.
interface match_select_if;
    import match_pkg::*;

    logic                startsig;
    logic                valid;
    logic [RESULT_W-1:0] result;
    logic [PLACE_W-1:0]  place;

    logic                busy;
    logic                done;
    logic [PLACE_W-1:0]  best_place;
    logic [RESULT_W-1:0] best_result;
    logic [RESULT_W-1:0] second_result;
    logic [RESULT_W-1:0] margin;
    logic                conf;

    // The search block is the slave; whoever feeds samples is the master.
    modport master (
        output startsig, valid, result, place,
        input  busy, done, best_place, best_result, second_result, margin, conf
    );

    modport slave (
        input  startsig, valid, result, place,
        output busy, done, best_place, best_result, second_result, margin, conf
    );

endinterface

// File: rtl/match_cmp2.sv
// Combinational top-two update: folds one sample into the running best/second pair.
module match_cmp2
    import match_pkg::*;
(
    input  logic [RESULT_W-1:0] best,
    input  logic [RESULT_W-1:0] second,
    input  logic [PLACE_W-1:0]  best_place,
    input  logic [RESULT_W-1:0] result,
    input  logic [PLACE_W-1:0]  place,
    output logic [RESULT_W-1:0] nxt_best,
    output logic [RESULT_W-1:0] nxt_second,
    output logic [PLACE_W-1:0]  nxt_best_place
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        nxt_best       = best;
        nxt_second     = second;
        nxt_best_place = best_place;
        // Strict '>' keeps the earliest of equal scores as best; a tie still lands in second.
        if (result > best) begin
            nxt_second     = best;
            nxt_best       = result;
            nxt_best_place = place;
        end else if (result > second) begin
            nxt_second = result;
        end
    end

endmodule

// File: rtl/match_select.sv
// Collects NCAND scored candidates, tracks best and second-best, and reports margin/confidence.
module match_select
    import match_pkg::*;
#(
    parameter int                  NCAND  = 32,
    parameter logic [RESULT_W-1:0] THRESH = 18'd64
) (
    input  logic           clk,
    input  logic           rst_n,
    match_select_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCAND - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [RESULT_W-1:0] best;
    logic [RESULT_W-1:0] second;
    logic [PLACE_W-1:0]  best_place;
    logic [RESULT_W-1:0] margin_q;
    logic                conf_q;
    logic                done_q;

    logic [RESULT_W-1:0] nxt_best;
    logic [RESULT_W-1:0] nxt_second;
    logic [PLACE_W-1:0]  nxt_best_place;
    logic [RESULT_W-1:0] nxt_margin;
    logic                accept;

    match_cmp2 u_cmp (
        .best           (best),
        .second         (second),
        .best_place     (best_place),
        .result         (bus.result),
        .place          (bus.place),
        .nxt_best       (nxt_best),
        .nxt_second     (nxt_second),
        .nxt_best_place (nxt_best_place)
    );

    // second never exceeds best, so this subtraction cannot wrap.
    assign nxt_margin = nxt_best - nxt_second;
    assign accept     = (state == COLLECT) && bus.valid && !bus.startsig;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments only, so every read sees pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            best       <= '0;
            second     <= '0;
            best_place <= '0;
            margin_q   <= '0;
            conf_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.startsig) begin
                // A start in any state clears the search; done already showing in REPORT is unaffected.
                state      <= COLLECT;
                cnt        <= '0;
                best       <= '0;
                second     <= '0;
                best_place <= '0;
                margin_q   <= '0;
                conf_q     <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    COLLECT: begin
                        if (accept) begin
                            best       <= nxt_best;
                            second     <= nxt_second;
                            best_place <= nxt_best_place;
                            cnt        <= cnt + CNT_W'(1);
                            if (cnt == LAST_IDX) begin
                                state    <= REPORT;
                                done_q   <= 1'b1;
                                margin_q <= nxt_margin;
                                conf_q   <= (nxt_margin >= THRESH);
                            end
                        end
                    end
                    REPORT:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy          = (state == COLLECT);
    assign bus.done          = done_q;
    assign bus.best_place    = best_place;
    assign bus.best_result   = best;
    assign bus.second_result = second;
    assign bus.margin        = margin_q;
    assign bus.conf          = conf_q;

endmodule

// File: tb/tb_match_select.sv
// Directed bench for match_select with NCAND=4, THRESH=64: vector table plus corner-case sequences.
module tb_match_select;
    import match_pkg::*;

    typedef struct packed {
        logic [3:0][RESULT_W-1:0] r;
        logic [PLACE_W-1:0]       pbase;
        logic [PLACE_W-1:0]       e_place;
        logic [RESULT_W-1:0]      e_best;
        logic [RESULT_W-1:0]      e_second;
        logic [RESULT_W-1:0]      e_margin;
        logic                     e_conf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   d0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    match_select_if bus ();

    match_select #(.NCAND(4), .THRESH(18'd64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // done is sampled before the edge updates it, so each high cycle counts once.
    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] p, input logic [17:0] b,
                              input logic [17:0] s, input logic [17:0] m, input logic c);
        check({tag, ".best_place"},    32'(bus.best_place),    32'(p));
        check({tag, ".best_result"},   32'(bus.best_result),   32'(b));
        check({tag, ".second_result"}, 32'(bus.second_result), 32'(s));
        check({tag, ".margin"},        32'(bus.margin),        32'(m));
        check({tag, ".conf"},          32'(bus.conf),          32'(c));
    endtask

    // Applies inputs for one clock; returns at the following negedge with post-edge outputs.
    task automatic cyc(input logic st, input logic v, input logic [17:0] r, input logic [7:0] p);
        bus.startsig = st;
        bus.valid    = v;
        bus.result   = r;
        bus.place    = p;
        @(negedge clk);
    endtask

    task automatic add_vec(input logic [17:0] r0, r1, r2, r3, input logic [7:0] pbase,
                           input logic [7:0] ep, input logic [17:0] eb, es, em, input logic ec);
        vec_t v;
        v.r        = {r3, r2, r1, r0};
        v.pbase    = pbase;
        v.e_place  = ep;
        v.e_best   = eb;
        v.e_second = es;
        v.e_margin = em;
        v.e_conf   = ec;
        vecs.push_back(v);
    endtask

    task automatic run_search(input string tag, input vec_t v);
        cyc(1'b1, 1'b0, '0, '0);
        check({tag, ".busy_after_start"}, 32'(bus.busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, v.r[k], v.pbase + 8'(k));
            if (k < 3) check({tag, ".no_early_done"}, 32'(bus.done), 32'd0);
        end
        check({tag, ".done"}, 32'(bus.done), 32'd1);
        check({tag, ".busy_in_report"}, 32'(bus.busy), 32'd0);
        check_outs(tag, v.e_place, v.e_best, v.e_second, v.e_margin, v.e_conf);
        cyc(1'b0, 1'b0, '0, '0);
        check({tag, ".done_one_cycle"}, 32'(bus.done), 32'd0);
        check_outs({tag, ".hold"}, v.e_place, v.e_best, v.e_second, v.e_margin, v.e_conf);
    endtask

    initial begin
        bus.startsig = 1'b0;
        bus.valid    = 1'b0;
        bus.result   = '0;
        bus.place    = '0;

        add_vec(18'd10,     18'd50, 18'd30, 18'd20, 8'd0,  8'd1,  18'd50,     18'd30, 18'd20,     1'b0);
        add_vec(18'd200,    18'd40, 18'd40, 18'd5,  8'd7,  8'd7,  18'd200,    18'd40, 18'd160,    1'b1);
        add_vec(18'd40,     18'd40, 18'd1,  18'd1,  8'd3,  8'd3,  18'd40,     18'd40, 18'd0,      1'b0);
        add_vec(18'd262143, 18'd0,  18'd0,  18'd0,  8'd0,  8'd0,  18'd262143, 18'd0,  18'd262143, 1'b1);
        add_vec(18'd36,     18'd100, 18'd0, 18'd0,  8'd20, 8'd21, 18'd100,    18'd36, 18'd64,     1'b1);
        add_vec(18'd37,     18'd100, 18'd0, 18'd0,  8'd30, 8'd31, 18'd100,    18'd37, 18'd63,     1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check_outs("reset", 8'd0, 18'd0, 18'd0, 18'd0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_search($sformatf("vec%0d", i), vecs[i]);

        // Valid in IDLE, valid on the start cycle, and a 5-cycle gap are all ignored.
        cyc(1'b0, 1'b1, 18'd5000, 8'd99);
        cyc(1'b0, 1'b1, 18'd5000, 8'd99);
        check("idle_valid.busy", 32'(bus.busy), 32'd0);
        cyc(1'b1, 1'b1, 18'd100000, 8'd98);
        check("start_valid.best_result", 32'(bus.best_result), 32'd0);
        cyc(1'b0, 1'b1, 18'd262143, 8'd40);
        repeat (5) cyc(1'b0, 1'b0, 18'd7, 8'd0);
        check("gap.busy", 32'(bus.busy), 32'd1);
        check("gap.no_done", 32'(bus.done), 32'd0);
        for (int k = 1; k < 4; k++) cyc(1'b0, 1'b1, 18'd0, 8'(40 + k));
        check("gap.done", 32'(bus.done), 32'd1);
        check_outs("gap", 8'd40, 18'd262143, 18'd0, 18'd262143, 1'b1);
        cyc(1'b0, 1'b0, '0, '0);

        // Abort after two samples, then a full search: exactly one done.
        cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 18'd300, 8'd1);
        cyc(1'b0, 1'b1, 18'd500, 8'd2);
        d0 = done_cnt;
        cyc(1'b1, 1'b0, '0, '0);
        check("abort.busy", 32'(bus.busy), 32'd1);
        check("abort.cleared", 32'(bus.best_result), 32'd0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 18'(k + 1), 8'(4 + k));
        check("abort.done", 32'(bus.done), 32'd1);
        check_outs("abort", 8'd7, 18'd4, 18'd3, 18'd1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, '0, '0);
        check("abort.single_done", 32'(done_cnt - d0), 32'd1);

        // startsig during REPORT begins a new search straight away.
        cyc(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 18'(10 * (k + 1)), 8'(k + 1));
        check("rpt_start.done", 32'(bus.done), 32'd1);
        check_outs("rpt_first", 8'd4, 18'd40, 18'd30, 18'd10, 1'b0);
        cyc(1'b1, 1'b0, '0, '0);
        check("rpt_start.busy", 32'(bus.busy), 32'd1);
        check("rpt_start.done_low", 32'(bus.done), 32'd0);
        check("rpt_start.cleared", 32'(bus.best_result), 32'd0);
        check("rpt_start.margin_cleared", 32'(bus.margin), 32'd0);
        cyc(1'b0, 1'b1, 18'd100, 8'd50);
        for (int k = 1; k < 4; k++) cyc(1'b0, 1'b1, 18'd0, 8'(50 + k));
        check("rpt_second.done", 32'(bus.done), 32'd1);
        check_outs("rpt_second", 8'd50, 18'd100, 18'd0, 18'd100, 1'b1);
        cyc(1'b0, 1'b0, '0, '0);

        // Asynchronous reset mid-search clears everything immediately and yields no done.
        cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 18'd1000, 8'd1);
        cyc(1'b0, 1'b1, 18'd2000, 8'd2);
        cyc(1'b0, 1'b1, 18'd3000, 8'd3);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.busy", 32'(bus.busy), 32'd0);
        check("rst_mid.done", 32'(bus.done), 32'd0);
        check_outs("rst_mid", 8'd0, 18'd0, 18'd0, 18'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cyc(1'b0, 1'b1, 18'd77, 8'd1);
        check("rst_after.busy", 32'(bus.busy), 32'd0);
        check("rst_after.no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_after.best_result", 32'(bus.best_result), 32'd0);
        run_search("rst_fresh", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
